mem_port_initiator: RTL and testbench

MEM_PORT_INITIATOR -- requirements
Module: mem_port_initiator

---
 rtl/mem_port_initiator.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_initiator.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_initiator.sv
// Memory-port initiator: accepts a clocked request and runs it over five
// four-phase channels (Access, Mode, Do, Di, Abort). It returns read data and
// the abort flag on a clocked response handshake.
module mem_port_initiator #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rnw,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_mode,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_abort,
   output logic        busy,
   output logic        Access_0r,
   input  logic        Access_0a,
   output logic [37:0] Access_0d,
   output logic        Mode_0r,
   input  logic        Mode_0a,
   output logic        Mode_0d,
   output logic        Do_0r,
   input  logic        Do_0a,
   output logic [31:0] Do_0d,
   output logic        Di_0r,
   input  logic        Di_0a,
   input  logic [31:0] Di_0d,
   output logic        Abort_0r,
   input  logic        Abort_0a,
   input  logic        Abort_0d
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACC,
      S_DATA,
      S_RTZ,
      S_RESP
   } state_t;

   // bit positions of each channel in the request/acknowledge vectors
   localparam int unsigned CH_ACC  = 0;
   localparam int unsigned CH_MODE = 1;
   localparam int unsigned CH_DO   = 2;
   localparam int unsigned CH_DI   = 3;
   localparam int unsigned CH_ABT  = 4;

   state_t      state_q, state_d;
   logic [4:0]  req_q, req_d;
   logic        ready_q, ready_d;
   logic        rnw_q, rnw_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        mode_q, mode_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        abort_q, abort_d;

   logic [4:0]  ack_raw;
   logic [4:0]  ack_s;
   logic [4:0]  sync_q [SYNC_STAGES];

   assign ack_raw = {Abort_0a, Di_0a, Do_0a, Mode_0a, Access_0a};
   assign ack_s   = sync_q[SYNC_STAGES-1];

   // acknowledge synchronisers, one SYNC_STAGES-deep chain per channel
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= ack_raw;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   // state, channel requests, latched request fields and response registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         req_q   <= '0;
         ready_q <= 1'b0;
         rnw_q   <= 1'b0;
         addr_q  <= '0;
         size_q  <= '0;
         mode_q  <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         ready_q <= ready_d;
         rnw_q   <= rnw_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         mode_q  <= mode_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         abort_q <= abort_d;
      end
   end

   // next-state and next-register logic; every *_0r edge is decided here and
   // registered, so each request changes only on a state transition
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      rnw_d   = rnw_q;
      addr_d  = addr_q;
      size_d  = size_q;
      mode_d  = mode_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      abort_d = abort_q;

      case (state_q)
         S_IDLE: begin
            if (ready_q && req_valid) begin
               rnw_d           = req_rnw;
               addr_d          = req_addr;
               size_d          = req_size;
               mode_d          = req_mode;
               wdata_d         = req_wdata;
               req_d[CH_ACC]   = 1'b1;
               req_d[CH_MODE]  = 1'b1;
               req_d[CH_DO]    = ~req_rnw;
               state_d         = S_ACC;
            end
         end
         S_ACC: begin
            if (ack_s[CH_ACC] && ack_s[CH_MODE]) begin
               req_d[CH_ABT] = 1'b1;
               req_d[CH_DI]  = rnw_q;
               state_d       = S_DATA;
            end
         end
         S_DATA: begin
            if (ack_s[CH_ABT] && (rnw_q ? ack_s[CH_DI] : ack_s[CH_DO])) begin
               rdata_d = rnw_q ? Di_0d : '0;
               abort_d = Abort_0d;
               req_d   = '0;
               state_d = S_RTZ;
            end
         end
         S_RTZ: begin
            if (ack_s == '0) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // registered ready: low through reset, high from the first edge in IDLE
      ready_d = (state_d == S_IDLE);
   end

   assign req_ready = ready_q;
   assign busy      = (state_q != S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_abort = abort_q;

   assign Access_0r = req_q[CH_ACC];
   assign Mode_0r   = req_q[CH_MODE];
   assign Do_0r     = req_q[CH_DO];
   assign Di_0r     = req_q[CH_DI];
   assign Abort_0r  = req_q[CH_ABT];

   assign Access_0d = {3'b000, size_q, addr_q, rnw_q};
   assign Mode_0d   = mode_q;
   assign Do_0d     = wdata_q;

endmodule

// File: tb/tb_mem_port_initiator.sv
// Bench for mem_port_initiator: directed transactions plus a randomised
// acknowledge-delay run against a four-phase responder and protocol monitor.
module tb_mem_port_initiator;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid, req_ready, req_rnw, req_mode;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        rsp_valid, rsp_ready, rsp_abort, busy;
   logic [31:0] rsp_rdata;
   logic        Access_0r, Mode_0r, Do_0r, Di_0r, Abort_0r;
   logic [37:0] Access_0d;
   logic        Mode_0d;
   logic [31:0] Do_0d;
   logic [4:0]  a_vec;
   logic [4:0]  r_vec;
   logic [31:0] di_val;
   logic        ab_val;
   int unsigned max_dly;
   int unsigned cnt [5];

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;
   int unsigned viol = 0;
   int unsigned rsp_cnt = 0;
   int unsigned exp_rsp = 0;

   logic [4:0]  r_prev = '0, a_prev = '0;
   logic        rsp_v_prev = 1'b0;
   logic [37:0] acc_seen = '0;
   logic        mode_seen = 1'b0;
   logic [31:0] do_seen = '0;
   logic        do_with_acc = 1'b0;
   logic [4:0]  rtz_r = '0;

   assign r_vec = {Abort_0r, Di_0r, Do_0r, Mode_0r, Access_0r};

   mem_port_initiator #(.SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_rnw(req_rnw), .req_addr(req_addr), .req_size(req_size),
      .req_mode(req_mode), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_abort(rsp_abort), .busy(busy),
      .Access_0r(Access_0r), .Access_0a(a_vec[0]), .Access_0d(Access_0d),
      .Mode_0r(Mode_0r), .Mode_0a(a_vec[1]), .Mode_0d(Mode_0d),
      .Do_0r(Do_0r), .Do_0a(a_vec[2]), .Do_0d(Do_0d),
      .Di_0r(Di_0r), .Di_0a(a_vec[3]), .Di_0d(di_val),
      .Abort_0r(Abort_0r), .Abort_0a(a_vec[4]), .Abort_0d(ab_val)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   // responder: each ack follows its request after 0..max_dly cycles
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         a_vec <= '0;
         for (int c = 0; c < 5; c++) cnt[c] <= 0;
      end else begin
         for (int c = 0; c < 5; c++) begin
            if (r_vec[c] != a_vec[c]) begin
               if (cnt[c] == 0) begin
                  a_vec[c] <= r_vec[c];
                  cnt[c]   <= $urandom_range(max_dly, 0);
               end else begin
                  cnt[c] <= cnt[c] - 1;
               end
            end
         end
      end
   end

   // response counter on completed handshakes
   always @(posedge clk) begin
      if (!reset && rsp_valid && rsp_ready) rsp_cnt++;
   end

   // four-phase and data-stability monitor
   always @(negedge clk) begin
      if (reset) begin
         r_prev = '0;
         a_prev = '0;
         rsp_v_prev = 1'b0;
      end else begin
         for (int c = 0; c < 5; c++) begin
            if (r_vec[c] && !r_prev[c] && a_prev[c]) viol++;
            if (!r_vec[c] && r_prev[c] && !a_prev[c]) viol++;
         end
         if (r_vec[0] && !r_prev[0]) begin
            acc_seen    = Access_0d;
            mode_seen   = Mode_0d;
            do_seen     = Do_0d;
            do_with_acc = r_vec[2];
         end else if ((|r_prev) || (|a_prev)) begin
            if (Access_0d !== acc_seen || Mode_0d !== mode_seen || Do_0d !== do_seen) viol++;
         end
         if (rsp_valid && !rsp_v_prev && r_vec != '0) viol++;
         r_prev = r_vec;
         a_prev = a_vec;
         rsp_v_prev = rsp_valid;
      end
   end

   task automatic issue(input logic rnw, input logic [31:0] addr, input logic [1:0] size,
                        input logic mode, input logic [31:0] wd);
      int unsigned t = 0;
      while (!req_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) chk("req_ready_timeout", req_ready, 1);
      req_valid = 1'b1;
      req_rnw   = rnw;
      req_addr  = addr;
      req_size  = size;
      req_mode  = mode;
      req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output logic [31:0] rd, output logic ab, output logic ok);
      int unsigned t = 0;
      while (!rsp_valid && t < 500) begin
         @(negedge clk);
         t++;
      end
      ok    = rsp_valid;
      rd    = rsp_rdata;
      ab    = rsp_abort;
      rtz_r = r_vec;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic run(input string tag, input logic rnw, input logic [31:0] addr,
                      input logic [1:0] size, input logic mode, input logic [31:0] wd,
                      input logic [31:0] di, input logic ab);
      logic [31:0] rd;
      logic        rab;
      logic        ok;
      di_val = di;
      ab_val = ab;
      issue(rnw, addr, size, mode, wd);
      wait_rsp(rd, rab, ok);
      exp_rsp++;
      chk({tag, "_rsp"}, ok, 1);
      chk({tag, "_rdata"}, rd, rnw ? di : 32'h0);
      chk({tag, "_abort"}, rab, ab);
      chk({tag, "_acc_d"}, acc_seen, {3'b000, size, addr, rnw});
      chk({tag, "_mode_d"}, mode_seen, mode);
      chk({tag, "_do_r"}, do_with_acc, !rnw);
      if (!rnw) chk({tag, "_do_d"}, do_seen, wd);
   endtask

   initial begin
      logic [31:0] rd0;
      logic        ab0;
      int unsigned bad, rdy, cnt0, t;
      req_valid = 1'b0; req_rnw = 1'b0; req_addr = '0; req_size = '0;
      req_mode = 1'b0; req_wdata = '0; rsp_ready = 1'b0;
      di_val = '0; ab_val = 1'b0; max_dly = 0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req_vec", r_vec, 0);
      chk("rst_acc_d", Access_0d, 0);
      chk("rst_rdata", rsp_rdata, 0);
      reset = 1'b0;
      #1 chk("rel_ready_low", req_ready, 0);
      @(negedge clk);
      chk("rel_ready_high", req_ready, 1);

      // word read
      run("rd", 1'b1, 32'h0000_0100, 2'd2, 1'b1, 32'h0, 32'hDEAD_BEEF, 1'b0);
      chk("rd_acc_const", acc_seen, 38'h4_0000_0201);

      // byte write
      run("wr", 1'b0, 32'h0000_C000, 2'd0, 1'b0, 32'h0000_0041, 32'hAAAA_5555, 1'b0);

      // read abort
      run("abt", 1'b1, 32'h0004_0000, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b1);
      chk("abt_rtz_low", rtz_r, 0);

      // back-pressure with req_valid toggling
      di_val = 32'h1234_5678;
      ab_val = 1'b0;
      issue(1'b1, 32'h0000_0200, 2'd2, 1'b0, 32'h0);
      t = 0;
      while (!rsp_valid && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("bp_rsp", rsp_valid, 1);
      rd0 = rsp_rdata;
      ab0 = rsp_abort;
      bad = 0;
      rdy = 0;
      for (int i = 0; i < 10; i++) begin
         req_valid = (i % 2 == 0);
         req_addr  = $urandom;
         @(negedge clk);
         if (rsp_rdata !== rd0 || rsp_abort !== ab0 || !rsp_valid) bad++;
         if (req_ready) rdy++;
      end
      req_valid = 1'b0;
      chk("bp_stable", bad, 0);
      chk("bp_ready_low", rdy, 0);
      chk("bp_rdata", rd0, 32'h1234_5678);
      cnt0 = rsp_cnt;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      exp_rsp++;
      repeat (3) @(negedge clk);
      chk("bp_one_rsp", rsp_cnt - cnt0, 1);
      chk("bp_idle", busy, 0);

      // reset during DATA
      max_dly = 15;
      di_val = 32'h0BAD_F00D;
      issue(1'b1, 32'h0000_0300, 2'd2, 1'b0, 32'h0);
      t = 0;
      while (!Abort_0r && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("rstmid_in_data", Abort_0r, 1);
      cnt0 = rsp_cnt;
      #2 reset = 1'b1;
      #1;
      chk("rstmid_req_vec", r_vec, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_valid", rsp_valid, 0);
      chk("rstmid_ready", req_ready, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      max_dly = 0;
      repeat (3) @(negedge clk);
      chk("rstmid_no_rsp", rsp_cnt - cnt0, 0);
      run("rst_rd", 1'b1, 32'h0000_0100, 2'd2, 1'b1, 32'h0, 32'hCAFE_0001, 1'b0);

      // randomised acknowledge delays
      max_dly = 20;
      for (int n = 0; n < 200; n++) begin
         logic        rnw;
         logic [1:0]  sz;
         rnw = 1'($urandom_range(1, 0));
         sz  = 2'($urandom_range(2, 0));
         run("rnd", rnw, $urandom, sz, 1'($urandom_range(1, 0)), $urandom, $urandom,
             1'($urandom_range(1, 0)));
      end

      repeat (5) @(negedge clk);
      chk("protocol_viol", viol, 0);
      chk("rsp_count", rsp_cnt, exp_rsp);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
